uart_tx_serializer: RTL

Transmit-side UART stage that feeds RX_IN of the UART_RX block on a serial link. It accepts a parallel byte through a valid/ready handshake and serializes it as a frame: start bit, data bits LSB first, optional parity bit, then one stop bit. The block is clocked at the bit rate (TX_CLK, 115.2 kHz nominal), so each bit lasts exactly one CLK cycle.

---
 rtl/uart_tx_serializer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer (start, data LSB first, optional parity, stop); optional macro UART_TX_HOLD_EN adds a one-entry hold register
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  in_ready,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_bit_cnt;
   logic [CW-1:0]         w_bit_cnt_nxt;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_par_en;
   logic                  r_par_typ;
   logic                  r_tx;
   logic                  r_busy;
   logic                  w_tx_nxt;
   logic                  w_accept;
   logic                  w_load;
   logic [DATA_WIDTH-1:0] w_load_data;
   logic                  w_load_par_en;
   logic                  w_load_par_typ;

`ifdef UART_TX_HOLD_EN
   logic                  r_hold_full;
   logic [DATA_WIDTH-1:0] r_hold_data;
   logic                  r_hold_par_en;
   logic                  r_hold_par_typ;
   logic                  w_hold_pop;
   logic                  w_hold_push;

   // Ready whenever the single hold slot is free; reset forces not-ready.
   assign in_ready    = !r_hold_full && !RST;
   // An accepted word not consumed directly by the frame registers is queued.
   assign w_hold_push = w_accept && !(w_load && !w_hold_pop);
`else
   // Without the hold slot a word is only taken while the line is idle.
   assign in_ready = (r_state == S_IDLE) && !RST;
`endif

   assign w_accept = Data_Valid && in_ready;
   assign TX_OUT   = r_tx;
   assign Busy     = r_busy;

   // Next-state, frame-load selection and registered-output precompute.
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_load         = 1'b0;
      w_load_data    = P_DATA;
      w_load_par_en  = PAR_EN;
      w_load_par_typ = PAR_TYP;
      w_tx_nxt       = 1'b1;
`ifdef UART_TX_HOLD_EN
      w_hold_pop     = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_load      = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_DATA;
         end
         S_DATA: begin
            if (r_bit_cnt == LAST_BIT) begin
               w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            end else begin
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end
         S_PARITY: begin
            w_state_nxt = S_STOP;
         end
         S_STOP: begin
            w_state_nxt = S_IDLE;
`ifdef UART_TX_HOLD_EN
            // Queued word wins; otherwise a word arriving now passes straight through.
            if (r_hold_full) begin
               w_load         = 1'b1;
               w_hold_pop     = 1'b1;
               w_load_data    = r_hold_data;
               w_load_par_en  = r_hold_par_en;
               w_load_par_typ = r_hold_par_typ;
               w_state_nxt    = S_START;
            end else if (w_accept) begin
               w_load      = 1'b1;
               w_state_nxt = S_START;
            end
`endif
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Line level for the state being entered; TX_OUT is registered.
      case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = r_data[w_bit_cnt_nxt];
         S_PARITY: w_tx_nxt = r_par_typ ? ~(^r_data) : (^r_data);
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   // State, counter, line and frame registers; reset aborts any frame.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_data    <= '0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_tx      <= w_tx_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
         if (w_load) begin
            r_data    <= w_load_data;
            r_par_en  <= w_load_par_en;
            r_par_typ <= w_load_par_typ;
         end
      end
   end

`ifdef UART_TX_HOLD_EN
   // One-entry hold slot: filled by a queued accept, emptied when STOP drains it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_hold_full    <= 1'b0;
         r_hold_data    <= '0;
         r_hold_par_en  <= 1'b0;
         r_hold_par_typ <= 1'b0;
      end else if (w_hold_push) begin
         r_hold_full    <= 1'b1;
         r_hold_data    <= P_DATA;
         r_hold_par_en  <= PAR_EN;
         r_hold_par_typ <= PAR_TYP;
      end else if (w_hold_pop) begin
         r_hold_full <= 1'b0;
      end
   end
`endif

endmodule
